rsc_encoder: RTL
================

RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 21, meaning information bits per block.
REQ-002 SHALL have port clk_p_i  input  1  the single clock for all logic.
REQ-003 SHALL have port reset_n_i  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port in_valid_i  input  1  high when in_bit_i holds a valid information bit.
REQ-005 SHALL have port in_bit_i  input  1  information bit.
REQ-006 SHALL have port in_ready_o  output  1  high when the block accepts an information bit this cycle.
REQ-007 SHALL have port out_valid_o  output  1  high when the output fields hold a valid symbol.
REQ-008 SHALL have port out_ready_i  input  1  high when the downstream block consumes the symbol.
REQ-009 SHALL have port sys_o  output  1  systematic bit.
REQ-010 SHALL have port par_o  output  1  parity bit.
REQ-011 SHALL have port tail_o  output  1  high when the symbol is a termination symbol.
REQ-012 SHALL have port last_o  output  1  high when the symbol is the final symbol of the block.

Function
REQ-013 SHALL hold a 2-bit trellis state s={s[1],s[0]}, where feedback a = u XOR s[0], parity p = a, and next state = {a, s[1]}.
REQ-014 SHALL realise these (state, u) -> (p, next) transitions: 0,0->0,0; 0,1->1,2; 1,0->1,2; 1,1->0,0; 2,0->0,1; 2,1->1,3; 3,0->1,3; 3,1->0,1.
REQ-015 SHALL use FSM states DATA and TAIL, with a bit counter of width clog2(BLOCK_SIZE+2).
REQ-016 SHALL drive in_ready_o = (fsm==DATA) AND (NOT out_valid_o OR out_ready_i), with no combinational path from in_valid_i.
REQ-017 SHALL, on an accept (in_valid_i AND in_ready_o), register sys_o=u, par_o=p, tail_o=0, out_valid_o=1, advance s, and increment the counter.
REQ-018 SHALL give 1 cycle of latency: the symbol appears the cycle after the accept.
REQ-019 SHALL, after the accept with counter==BLOCK_SIZE-1, enter TAIL.
REQ-020 SHALL, in TAIL, emit 2 termination symbols whenever the output register is free or consumed, each using u=s[0] (so a=0): sys_o=s[0], par_o=0, tail_o=1.
REQ-021 SHALL assert last_o with the second tail symbol, which returns s to 0.
REQ-022 SHALL, after the second tail symbol is loaded, return to DATA with counter=0 and s=0.
REQ-023 SHALL keep the output register and its fields stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL clear out_valid_o on consume when no new symbol is loaded in the same cycle.
REQ-025 SHALL support back-to-back operation: consume and load in the same cycle give one symbol per cycle.
REQ-026 SHALL ignore in_valid_i during TAIL, with in_ready_o=0.
REQ-027 SHALL, on the counter wrap at BLOCK_SIZE+1, never exceed the block; the next block starts with s=0.

Reset
REQ-028 SHALL, while reset_n_i=0 at a clk_p_i edge, set fsm=DATA, s=0, counter=0, out_valid_o=0, sys_o=0, par_o=0, tail_o=0, last_o=0.
REQ-029 SHALL drive in_ready_o=0 during reset.
REQ-030 SHALL, on reset mid-block or mid-tail, discard the partial block and the pending symbol; the first accept after reset is bit 0 of a new block.

Structure
REQ-031 SHALL take BLOCK_SIZE, the trellis state type, the FSM state enum, and the next-state/parity function from shared package turbo_pkg, which the decoder also uses.
REQ-032 SHALL instantiate one combinational sub-module rsc_step (inputs s and u; outputs p and next s), used for both data and tail steps.

Verification
REQ-033 SHALL cover: 21 zeros, out_ready_i=1 -> 21 symbols with sys=0/par=0, then 2 tail symbols sys=0/par=0, last_o on the 23rd.
REQ-034 SHALL cover: impulse 1 then 20 zeros -> par=1 at bits 0,2,...,20 and 0 otherwise; tail sys=0,1, par=0,0; final s=0.
REQ-035 SHALL cover: out_ready_i=0 for 5 cycles mid-block -> fields frozen, in_ready_o=0, no lost or duplicated bit.
REQ-036 SHALL cover: two blocks streamed with in_valid_i=1 and out_ready_i=1 -> 46 symbols in 46 consecutive cycles after the first, in_ready_o low for exactly 2 cycles per block.
REQ-037 SHALL cover: reset asserted after the 10th accept -> next cycle out_valid_o=0; a new all-zero block reproduces the REQ-033 output.
REQ-038 SHALL cover: a random 21-bit block -> the stream matches a reference model of REQ-013, ending in s=0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared turbo-code definitions used by the RSC encoder and the decoder.
//   BLOCK_SIZE  : default information bits per block
//   trellis_t   : 2-bit constituent-code trellis state {s[1], s[0]}
//   enc_state_t : encoder block-sequencing states (DATA, TAIL)
//   rsc_next    : one trellis step, returns {parity, next_state}
package turbo_pkg;

  localparam int unsigned BLOCK_SIZE = 21;

  typedef logic [1:0] trellis_t;

  typedef enum logic {
    DATA = 1'b0,
    TAIL = 1'b1
  } enc_state_t;

  // Feedback a = u ^ s[0]; parity equals the feedback bit; shift it in at the top.
  function automatic logic [2:0] rsc_next(input trellis_t s, input logic u);
    logic a;
    a = u ^ s[0];
    return {a, a, s[1]};
  endfunction

endpackage

// File: rtl/rsc_step.sv
// Combinational single trellis step of the recursive systematic code.
//   s      : current trellis state
//   u      : input bit (information bit, or s[0] when terminating)
//   p      : parity bit for this step
//   s_next : trellis state after this step
module rsc_step
  import turbo_pkg::*;
(
  input  trellis_t s,
  input  logic     u,
  output logic     p,
  output trellis_t s_next
);

  always_comb begin
    {p, s_next} = rsc_next(s, u);
  end

endmodule

// File: rtl/rsc_encoder.sv
// Recursive systematic convolutional encoder with trellis termination.
// Each accepted information bit produces one {sys, par} symbol one cycle
// later; after BLOCK_SIZE bits two tail symbols drive the trellis back to 0.
//   clk_p_i     : clock
//   reset_n_i   : synchronous active-low reset
//   in_valid_i  : information bit valid
//   in_bit_i    : information bit
//   in_ready_o  : encoder accepts a bit this cycle
//   out_valid_o : output symbol valid
//   out_ready_i : downstream consumes the symbol
//   sys_o       : systematic bit
//   par_o       : parity bit
//   tail_o      : symbol is a termination symbol
//   last_o      : symbol is the final symbol of the block
module rsc_encoder
  import turbo_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = turbo_pkg::BLOCK_SIZE
) (
  input  logic clk_p_i,
  input  logic reset_n_i,
  input  logic in_valid_i,
  input  logic in_bit_i,
  output logic in_ready_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output logic sys_o,
  output logic par_o,
  output logic tail_o,
  output logic last_o
);

  localparam int unsigned CNT_W = $clog2(BLOCK_SIZE + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(BLOCK_SIZE + 1);

  enc_state_t       fsm, fsm_n;
  trellis_t         s, s_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid_n, sys_n, par_n, tail_n, last_n;

  logic     free;
  logic     accept;
  logic     step_u;
  logic     step_p;
  trellis_t step_s;

  // Output register may be (re)loaded when empty or being consumed.
  assign free       = !out_valid_o || out_ready_i;
  assign in_ready_o = reset_n_i && (fsm == DATA) && free;
  assign accept     = in_valid_i && in_ready_o;

  // Tail steps feed u = s[0] so the feedback is zero and the state drains.
  assign step_u = (fsm == TAIL) ? s[0] : in_bit_i;

  rsc_step u_step (
    .s      (s),
    .u      (step_u),
    .p      (step_p),
    .s_next (step_s)
  );

  always_comb begin
    fsm_n   = fsm;
    s_n     = s;
    cnt_n   = cnt;
    valid_n = out_valid_o;
    sys_n   = sys_o;
    par_n   = par_o;
    tail_n  = tail_o;
    last_n  = last_o;

    unique case (fsm)
      DATA: begin
        if (accept) begin
          valid_n = 1'b1;
          sys_n   = in_bit_i;
          par_n   = step_p;
          tail_n  = 1'b0;
          last_n  = 1'b0;
          s_n     = step_s;
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == LAST_DATA) begin
            fsm_n = TAIL;
          end
        end else if (out_ready_i) begin
          valid_n = 1'b0;
        end
      end
      TAIL: begin
        if (free) begin
          valid_n = 1'b1;
          sys_n   = s[0];
          par_n   = step_p;
          tail_n  = 1'b1;
          last_n  = (cnt == LAST_TAIL);
          s_n     = step_s;
          if (cnt == LAST_TAIL) begin
            fsm_n = DATA;
            cnt_n = '0;
            s_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        fsm_n = DATA;
      end
    endcase
  end

  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      fsm         <= DATA;
      s           <= '0;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      sys_o       <= 1'b0;
      par_o       <= 1'b0;
      tail_o      <= 1'b0;
      last_o      <= 1'b0;
    end else begin
      fsm         <= fsm_n;
      s           <= s_n;
      cnt         <= cnt_n;
      out_valid_o <= valid_n;
      sys_o       <= sys_n;
      par_o       <= par_n;
      tail_o      <= tail_n;
      last_o      <= last_n;
    end
  end

endmodule
